// File: rtl/stall_apply_ctrl.sv
// -----------------------------------------------------------------------------
// stall_apply_ctrl
//
// Consumer side of the data-hazard stall handshake, sitting between fetch and
// decode of the RV32I pipeline. Owns the PC register and the IF/ID register.
// Tells the ID/EXE register when to load a bubble. Keeps saturating
// stall/flush counters and a sticky stall watchdog.
//
// Hold semantics: a dstall input is a level request sampled at each rising
// edge. A register that is told to hold keeps its value across that edge.
// There is no ready/acknowledge back to the hazard unit. A later stage's
// hold always implies the earlier stages' holds, so no instruction is
// dropped.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   instr_in        imem data for the address on pc_out this cycle
//   PC_dstall       hold PC
//   IF_ID_dstall    hold IF/ID (implies PC hold)
//   ID_EXE_dstall   bubble ID/EXE (implies IF/ID and PC hold)
//   branch_taken    EXE-stage redirect; beats every stall
//   branch_target   redirect address (low two bits are dropped)
//   pc_out          fetch PC (registered)
//   if_id_pc        PC of the instruction held in IF/ID (registered)
//   if_id_instr     instruction held in IF/ID (registered)
//   if_id_valid     IF/ID holds a real instruction (registered)
//   id_exe_bubble   combinational; ID/EXE loads a NOP at the next edge
//   stall_active    previous edge was a stall edge
//   stall_total     saturating count of stall edges
//   flush_total     saturating count of flush edges
//   stall_timeout   sticky; MAX_STALL consecutive stall edges were seen
//   act_dbg         action that the next edge will apply (observability)
// -----------------------------------------------------------------------------
module stall_apply_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 16,
  parameter int          MAX_STALL = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_in,
  input  logic             PC_dstall,
  input  logic             IF_ID_dstall,
  input  logic             ID_EXE_dstall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  output logic [31:0]      pc_out,
  output logic [31:0]      if_id_pc,
  output logic [31:0]      if_id_instr,
  output logic             if_id_valid,
  output logic             id_exe_bubble,
  output logic             stall_active,
  output logic [CNT_W-1:0] stall_total,
  output logic [CNT_W-1:0] flush_total,
  output logic             stall_timeout,
  output logic [1:0]       act_dbg
);

  localparam int RUN_W = $clog2(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);

  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,
    ACT_STALL   = 2'd1,
    ACT_FLUSH   = 2'd2
  } act_e;

  act_e             act;
  logic             ifid_hold;
  logic             pc_hold;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_next;
  logic [31:0]      target_aligned;
  logic             unused_target_bits;

  assign ifid_hold = IF_ID_dstall | ID_EXE_dstall;
  assign pc_hold   = PC_dstall | ifid_hold;

  // Redirects are always word-aligned; the dropped bits are don't-care.
  assign target_aligned     = {branch_target[31:2], 2'b00};
  assign unused_target_bits = ^branch_target[1:0];

  assign id_exe_bubble = ID_EXE_dstall | branch_taken | ~if_id_valid;

  // Edge action, in priority order: flush beats stall beats advance.
  always_comb begin
    act = ACT_ADVANCE;
    if (branch_taken) begin
      act = ACT_FLUSH;
    end else if (pc_hold) begin
      act = ACT_STALL;
    end
  end

  assign act_dbg = act;

  // Consecutive-stall run length, saturating at the watchdog threshold.
  always_comb begin
    run_next = run_cnt;
    if (run_cnt != RUN_MAX) begin
      run_next = run_cnt + RUN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out        <= RESET_PC;
      if_id_pc      <= 32'd0;
      if_id_instr   <= NOP_INSTR;
      if_id_valid   <= 1'b0;
      stall_active  <= 1'b0;
      stall_total   <= '0;
      flush_total   <= '0;
      stall_timeout <= 1'b0;
      run_cnt       <= '0;
    end else begin
      case (act)
        ACT_FLUSH: begin
          pc_out       <= target_aligned;
          if_id_pc     <= 32'd0;
          if_id_instr  <= NOP_INSTR;
          if_id_valid  <= 1'b0;
          stall_active <= 1'b0;
          run_cnt      <= '0;
          if (flush_total != '1) begin
            flush_total <= flush_total + CNT_W'(1);
          end
        end
        ACT_STALL: begin
          // PC-only stall still moves the current fetch into IF/ID.
          if (!ifid_hold) begin
            if_id_pc    <= pc_out;
            if_id_instr <= instr_in;
            if_id_valid <= 1'b1;
          end
          stall_active <= 1'b1;
          run_cnt      <= run_next;
          if (run_next == RUN_MAX) begin
            stall_timeout <= 1'b1;
          end
          if (stall_total != '1) begin
            stall_total <= stall_total + CNT_W'(1);
          end
        end
        default: begin
          pc_out       <= pc_out + 32'd4;
          if_id_pc     <= pc_out;
          if_id_instr  <= instr_in;
          if_id_valid  <= 1'b1;
          stall_active <= 1'b0;
          run_cnt      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stall_apply_ctrl.sv
module tb_stall_apply_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] instr_in;
  logic        pc_ds, ifid_ds, idex_ds, br;
  logic [31:0] br_tgt;

  // Main instance (defaults) and a small instance for saturation corners.
  logic [31:0] a_pc, a_ifpc, a_ifinstr;
  logic        a_ifv, a_bub, a_sact, a_tmo;
  logic [15:0] a_stot, a_ftot;
  logic [1:0]  a_act;
  logic [31:0] b_pc, b_ifpc, b_ifinstr;
  logic        b_ifv, b_bub, b_sact, b_tmo;
  logic [1:0]  b_stot, b_ftot;
  logic [1:0]  b_act;

  stall_apply_ctrl dut (
    .clk(clk), .rst(rst), .instr_in(instr_in),
    .PC_dstall(pc_ds), .IF_ID_dstall(ifid_ds), .ID_EXE_dstall(idex_ds),
    .branch_taken(br), .branch_target(br_tgt),
    .pc_out(a_pc), .if_id_pc(a_ifpc), .if_id_instr(a_ifinstr),
    .if_id_valid(a_ifv), .id_exe_bubble(a_bub), .stall_active(a_sact),
    .stall_total(a_stot), .flush_total(a_ftot), .stall_timeout(a_tmo),
    .act_dbg(a_act)
  );

  stall_apply_ctrl #(.CNT_W(2), .MAX_STALL(3)) dut_small (
    .clk(clk), .rst(rst), .instr_in(instr_in),
    .PC_dstall(pc_ds), .IF_ID_dstall(ifid_ds), .ID_EXE_dstall(idex_ds),
    .branch_taken(br), .branch_target(br_tgt),
    .pc_out(b_pc), .if_id_pc(b_ifpc), .if_id_instr(b_ifinstr),
    .if_id_valid(b_ifv), .id_exe_bubble(b_bub), .stall_active(b_sact),
    .stall_total(b_stot), .flush_total(b_ftot), .stall_timeout(b_tmo),
    .act_dbg(b_act)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc, ifpc, ifinstr;
    bit          ifv, sact, tmo;
    int          stot, ftot, run;
  } mstate_t;

  mstate_t ma, mb;
  int n_checks = 0;
  int n_fail   = 0;

  function automatic mstate_t model_step(mstate_t s, int cnt_max, int max_stall,
                                         bit r, bit b, bit pds, bit ids, bit eds,
                                         logic [31:0] tgt, logic [31:0] ins);
    mstate_t n = s;
    if (r) begin
      n.pc = 0; n.ifpc = 0; n.ifinstr = NOP; n.ifv = 0;
      n.sact = 0; n.stot = 0; n.ftot = 0; n.tmo = 0; n.run = 0;
    end else if (b) begin
      n.pc = (tgt / 4) * 4;
      n.ifpc = 0; n.ifinstr = NOP; n.ifv = 0;
      n.sact = 0; n.run = 0;
      n.ftot = (s.ftot < cnt_max) ? s.ftot + 1 : cnt_max;
    end else if (pds || ids || eds) begin
      if (!(ids || eds)) begin
        n.ifpc = s.pc; n.ifinstr = ins; n.ifv = 1;
      end
      n.sact = 1;
      n.stot = (s.stot < cnt_max) ? s.stot + 1 : cnt_max;
      n.run  = (s.run < max_stall) ? s.run + 1 : max_stall;
      if (n.run == max_stall) n.tmo = 1;
    end else begin
      n.pc = s.pc + 32'd4;
      n.ifpc = s.pc; n.ifinstr = ins; n.ifv = 1;
      n.sact = 0; n.run = 0;
    end
    return n;
  endfunction

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_regs();
    check_eq("a.pc",      a_pc,      ma.pc);
    check_eq("a.ifpc",    a_ifpc,    ma.ifpc);
    check_eq("a.ifinstr", a_ifinstr, ma.ifinstr);
    check_eq("a.ifv",     32'(a_ifv),  32'(ma.ifv));
    check_eq("a.sact",    32'(a_sact), 32'(ma.sact));
    check_eq("a.stot",    32'(a_stot), 32'(ma.stot));
    check_eq("a.ftot",    32'(a_ftot), 32'(ma.ftot));
    check_eq("a.tmo",     32'(a_tmo),  32'(ma.tmo));
    check_eq("b.pc",      b_pc,      mb.pc);
    check_eq("b.ifpc",    b_ifpc,    mb.ifpc);
    check_eq("b.ifinstr", b_ifinstr, mb.ifinstr);
    check_eq("b.ifv",     32'(b_ifv),  32'(mb.ifv));
    check_eq("b.stot",    32'(b_stot), 32'(mb.stot));
    check_eq("b.ftot",    32'(b_ftot), 32'(mb.ftot));
    check_eq("b.tmo",     32'(b_tmo),  32'(mb.tmo));
  endtask

  // ---------------- driver ----------------
  // Inputs are applied just after a rising edge; the combinational bubble is
  // sampled at the falling edge; registers are checked 1ns after the next
  // rising edge against the model advanced by one step.
  task automatic cycle(input bit r, input bit b, input bit pds, input bit ids,
                       input bit eds, input logic [31:0] tgt, input logic [31:0] ins);
    rst = r; br = b; pc_ds = pds; ifid_ds = ids; idex_ds = eds;
    br_tgt = tgt; instr_in = ins;
    @(negedge clk);
    if (!r) begin
      check_eq("a.bubble", 32'(a_bub), 32'(eds || b || !ma.ifv));
      check_eq("b.bubble", 32'(b_bub), 32'(eds || b || !mb.ifv));
    end
    @(posedge clk);
    ma = model_step(ma, 65535, 8, r, b, pds, ids, eds, tgt, ins);
    mb = model_step(mb, 3, 3, r, b, pds, ids, eds, tgt, ins);
    #1;
    check_regs();
  endtask

  localparam logic [31:0] ADDI = 32'h0050_0093;

  initial begin
    ma = '{pc: 0, ifpc: 0, ifinstr: NOP, ifv: 0, sact: 0, tmo: 0, stot: 0, ftot: 0, run: 0};
    mb = ma;
    rst = 1; br = 0; pc_ds = 0; ifid_ds = 0; idex_ds = 0; br_tgt = 0; instr_in = 0;
    @(posedge clk); #1;

    // Reset values against constants.
    cycle(1, 0, 0, 0, 0, 0, ADDI);
    check_eq("rst.pc", a_pc, 32'h0);
    check_eq("rst.ifinstr", a_ifinstr, NOP);
    check_eq("rst.ifv", 32'(a_ifv), 32'h0);

    // Free-running fetch: 0 -> 4 -> 8.
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, 0, 0, 0, ADDI);
    check_eq("run.pc8", a_pc, 32'd8);
    check_eq("run.ifpc4", a_ifpc, 32'd4);

    // Full stall for 2 cycles at pc=8, then release.
    for (int i = 0; i < 2; i++) cycle(0, 0, 1, 1, 1, 0, ADDI);
    check_eq("stall.pc", a_pc, 32'd8);
    check_eq("stall.tot", 32'(a_stot), 32'd2);
    cycle(0, 0, 0, 0, 0, 0, ADDI);
    check_eq("release.pc", a_pc, 32'd12);

    // ID_EXE_dstall alone holds everything upstream.
    cycle(0, 0, 0, 0, 1, 0, 32'h1111_1111);
    check_eq("idex.pc", a_pc, 32'd12);
    // PC-only stall still loads IF/ID.
    cycle(0, 0, 1, 0, 0, 0, 32'h2222_2222);
    check_eq("pconly.ifinstr", a_ifinstr, 32'h2222_2222);

    // Flush beats every stall; misaligned target is aligned.
    cycle(0, 1, 1, 1, 1, 32'h0000_0103, ADDI);
    check_eq("flush.pc", a_pc, 32'h100);
    check_eq("flush.ftot", 32'(a_ftot), 32'd1);

    // Watchdog: 9 stall edges, then release, then reset clears it.
    for (int i = 0; i < 9; i++) cycle(0, 0, 1, 1, 1, 0, ADDI);
    cycle(0, 0, 0, 0, 0, 0, ADDI);
    check_eq("wd.sticky", 32'(a_tmo), 32'd1);
    cycle(1, 0, 1, 1, 1, 0, ADDI);
    check_eq("wd.clear", 32'(a_tmo), 32'd0);

    // PC wrap at the top of the address space.
    cycle(0, 1, 0, 0, 0, 32'hFFFF_FFF8, ADDI);
    cycle(0, 0, 0, 0, 0, 0, ADDI);
    check_eq("wrap.top", a_pc, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 0, 0, 0, ADDI);
    check_eq("wrap.zero", a_pc, 32'h0);

    // Small-counter flush saturation (total 6 flushes since reset).
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0, 32'($urandom), ADDI);
    check_eq("sat.ftot", 32'(b_ftot), 32'd3);

    // Randomized traffic with occasional long stall bursts.
    for (int i = 0; i < 600; i++) begin
      bit r, b, pds, ids, eds;
      int burst;
      r   = ($urandom_range(0, 99) < 2);
      b   = ($urandom_range(0, 99) < 8);
      pds = ($urandom_range(0, 99) < 25);
      ids = ($urandom_range(0, 99) < 20);
      eds = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 49) == 0) begin
        burst = $urandom_range(2, 10);
        for (int k = 0; k < burst; k++) cycle(0, 0, 1, 0, $urandom_range(0, 1), 0, $urandom);
      end
      cycle(r, b, pds, ids, eds, $urandom, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
